// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : RV32I memory stage. Performs loads and stores over a
//            request/ready data bus that may insert any number of wait
//            states. While an access is outstanding it stalls the upstream
//            pipeline. It delivers registered, sign- or zero-extended
//            write-back data to the WB stage.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            in_*                - execute-stage results and control
//            mem_stall           - hold upstream while an access is pending
//            dmem_*              - data-memory bus (req/ready handshake)
//            wb_*                - registered write-back outputs (1-cycle)
//            bus_err             - 1-cycle pulse on timeout/misalign abort
// Config   : MEM_MISALIGN_TRAP_EN - when defined, misaligned half/word
//            accesses are rejected with bus_err instead of being issued.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255  // 1..255 ACCESS cycles before abort
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_store_data,
  input  logic [4:0]  in_rd,
  input  logic [2:0]  in_funct3,
  input  logic        in_regwrite,
  input  logic        in_memread,
  input  logic        in_memwrite,
  input  logic        in_memtoreg,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_regwrite,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_wdata,
  output logic        bus_err
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  // FSM and latched request
  logic [0:0]  state_q,  state_d;
  logic [31:0] addr_q,   addr_d;
  logic [1:0]  lane_q,   lane_d;
  logic [1:0]  size_q,   size_d;
  logic        uns_q,    uns_d;
  logic        we_q,     we_d;
  logic [31:0] wdata_q,  wdata_d;
  logic [3:0]  wstrb_q,  wstrb_d;
  logic [4:0]  rd_q,     rd_d;
  logic [7:0]  cnt_q,    cnt_d;

  // Write-back registers
  logic        wb_valid_q,    wb_valid_d;
  logic        wb_regwrite_q, wb_regwrite_d;
  logic [4:0]  wb_rd_q,       wb_rd_d;
  logic [31:0] wb_wdata_q,    wb_wdata_d;
  logic        bus_err_q,     bus_err_d;

  // Request decode
  logic        w_memop;
  logic [1:0]  w_size;
  logic [31:0] w_st_data;
  logic [3:0]  w_st_strb;
  logic [7:0]  w_cnt_inc;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_ld_data;

  // Memtoreg is implied by memread in this stage; kept on the port for
  // pipeline-register symmetry only.
  logic        w_unused_memtoreg;
  assign w_unused_memtoreg = in_memtoreg;

  assign w_memop   = in_memread | in_memwrite;
  assign w_cnt_inc = cnt_q + 8'd1;

  // Size from funct3; the reserved encodings fall back to a word access.
  always_comb begin
    case (in_funct3)
      3'b000, 3'b100: w_size = SZ_BYTE;
      3'b001, 3'b101: w_size = SZ_HALF;
      default:        w_size = SZ_WORD;
    endcase
  end

  // Store lane replication and byte strobes
  always_comb begin
    case (w_size)
      SZ_BYTE: begin
        w_st_data = {4{in_store_data[7:0]}};
        w_st_strb = 4'b0001 << in_addr[1:0];
      end
      SZ_HALF: begin
        w_st_data = {2{in_store_data[15:0]}};
        w_st_strb = 4'b0011 << {in_addr[1], 1'b0};
      end
      default: begin
        w_st_data = in_store_data;
        w_st_strb = 4'b1111;
      end
    endcase
  end

  // Load lane extraction and extension
  always_comb begin
    case (lane_q)
      2'd0:    w_ld_byte = dmem_rdata[7:0];
      2'd1:    w_ld_byte = dmem_rdata[15:8];
      2'd2:    w_ld_byte = dmem_rdata[23:16];
      default: w_ld_byte = dmem_rdata[31:24];
    endcase
    w_ld_half = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (size_q)
      SZ_BYTE: w_ld_data = uns_q ? {24'd0, w_ld_byte}
                                 : {{24{w_ld_byte[7]}}, w_ld_byte};
      SZ_HALF: w_ld_data = uns_q ? {16'd0, w_ld_half}
                                 : {{16{w_ld_half[15]}}, w_ld_half};
      default: w_ld_data = dmem_rdata;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic w_misaligned;
  assign w_misaligned = ((w_size == SZ_HALF) && in_addr[0]) ||
                        ((w_size == SZ_WORD) && (in_addr[1:0] != 2'b00));
`endif

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    lane_d        = lane_q;
    size_d        = size_q;
    uns_d         = uns_q;
    we_d          = we_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    rd_d          = rd_q;
    cnt_d         = cnt_q;
    wb_valid_d    = 1'b0;
    wb_regwrite_d = 1'b0;
    wb_rd_d       = 5'd0;
    wb_wdata_d    = 32'd0;
    bus_err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (w_memop) begin
`ifdef MEM_MISALIGN_TRAP_EN
            if (w_misaligned) begin
              // Rejected without touching the bus; retire with an error.
              bus_err_d  = 1'b1;
              wb_valid_d = 1'b1;
              wb_rd_d    = in_rd;
            end else begin
`endif
              state_d = ACCESS;
              addr_d  = {in_addr[31:2], 2'b00};
              lane_d  = in_addr[1:0];
              size_d  = w_size;
              uns_d   = in_funct3[2];
              we_d    = in_memwrite;
              wdata_d = w_st_data;
              wstrb_d = w_st_strb;
              rd_d    = in_rd;
              cnt_d   = 8'd0;
`ifdef MEM_MISALIGN_TRAP_EN
            end
`endif
          end else begin
            wb_valid_d    = 1'b1;
            wb_regwrite_d = in_regwrite;
            wb_rd_d       = in_rd;
            wb_wdata_d    = in_addr;
          end
        end
      end
      default: begin
        // Completion has priority over a simultaneous timeout.
        if (dmem_ready) begin
          state_d       = IDLE;
          wb_valid_d    = 1'b1;
          wb_rd_d       = rd_q;
          wb_regwrite_d = ~we_q;
          wb_wdata_d    = we_q ? 32'd0 : w_ld_data;
        end else if (w_cnt_inc == TIMEOUT_LIMIT) begin
          state_d    = IDLE;
          cnt_d      = w_cnt_inc;
          bus_err_d  = 1'b1;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
        end else begin
          cnt_d = w_cnt_inc;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      addr_q        <= 32'd0;
      lane_q        <= 2'd0;
      size_q        <= SZ_BYTE;
      uns_q         <= 1'b0;
      we_q          <= 1'b0;
      wdata_q       <= 32'd0;
      wstrb_q       <= 4'd0;
      rd_q          <= 5'd0;
      cnt_q         <= 8'd0;
      wb_valid_q    <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_rd_q       <= 5'd0;
      wb_wdata_q    <= 32'd0;
      bus_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      lane_q        <= lane_d;
      size_q        <= size_d;
      uns_q         <= uns_d;
      we_q          <= we_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      rd_q          <= rd_d;
      cnt_q         <= cnt_d;
      wb_valid_q    <= wb_valid_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_rd_q       <= wb_rd_d;
      wb_wdata_q    <= wb_wdata_d;
      bus_err_q     <= bus_err_d;
    end
  end

  // Bus signals come straight from state, so they stay stable until ready.
  assign mem_stall   = (state_q == ACCESS);
  assign dmem_req    = (state_q == ACCESS);
  assign dmem_we     = (state_q == ACCESS) & we_q;
  assign dmem_wstrb  = (state_q == ACCESS) ? wstrb_q : 4'd0;
  assign dmem_addr   = addr_q;
  assign dmem_wdata  = wdata_q;

  assign wb_valid    = wb_valid_q;
  assign wb_regwrite = wb_regwrite_q;
  assign wb_rd       = wb_rd_q;
  assign wb_wdata    = wb_wdata_q;
  assign bus_err     = bus_err_q;

endmodule
`default_nettype wire
